ysyx_24100029_branch_predictor: RTL

//  Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.

---
 rtl/ysyx_24100029_branch_predictor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ysyx_24100029_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained from the resolved-branch stream.
module ysyx_24100029_branch_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] ifu_pc,
    output logic        pred_res,
    output logic [31:0] pred_pc,
    input  logic        br_valid,
    input  logic        br_is_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_npc,
    output logic [31:0] stat_upd_cnt,
    output logic [31:0] stat_alloc_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [1:0]         ctr_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        tgt_q [ENTRIES];
    logic [31:0]        upd_cnt_q;
    logic [31:0]        upd_cnt_d;
    logic [31:0]        alloc_cnt_q;
    logic [31:0]        alloc_cnt_d;

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               upd_en;
    logic               train_en;
    logic               alloc_en;
    logic               tgt_we;
    logic [1:0]         ctr_d;

    // Low pc bits never select an entry; instructions are word aligned.
    logic [3:0]         unused_pc_bits;
    assign unused_pc_bits = {ifu_pc[1:0], br_pc[1:0]};

    assign lk_idx   = ifu_pc[IDX_W+1:2];
    assign lk_tag   = ifu_pc[31:IDX_W+2];
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_res = lk_hit && ctr_q[lk_idx][1];
    assign pred_pc  = pred_res ? tgt_q[lk_idx] : ifu_pc + 32'd4;

    assign up_idx   = br_pc[IDX_W+1:2];
    assign up_tag   = br_pc[31:IDX_W+2];
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // A flush in the same cycle suppresses any BTB write from the update.
    assign upd_en   = br_valid && !flush;
    assign train_en = upd_en && up_hit;
    assign alloc_en = upd_en && !up_hit && br_is_taken;
    assign tgt_we   = alloc_en || (train_en && br_is_taken);

    always_comb begin
        ctr_d = ctr_q[up_idx];
        if (alloc_en) begin
            ctr_d = 2'b10;
        end else if (train_en) begin
            ctr_d = br_is_taken ? sat_inc(ctr_q[up_idx]) : sat_dec(ctr_q[up_idx]);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else if (alloc_en) begin
            valid_d[up_idx] = 1'b1;
        end
    end

    assign upd_cnt_d   = upd_cnt_q + {31'd0, br_valid};
    assign alloc_cnt_d = alloc_cnt_q + {31'd0, alloc_en};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            upd_cnt_q   <= '0;
            alloc_cnt_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            valid_q     <= valid_d;
            upd_cnt_q   <= upd_cnt_d;
            alloc_cnt_q <= alloc_cnt_d;
            if (alloc_en || train_en) begin
                ctr_q[up_idx] <= ctr_d;
            end
        end
    end

    // Tag/target storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            tag_q[up_idx] <= up_tag;
        end
        if (tgt_we) begin
            tgt_q[up_idx] <= br_npc;
        end
    end

    assign stat_upd_cnt   = upd_cnt_q;
    assign stat_alloc_cnt = alloc_cnt_q;

endmodule
